// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// register map and STATUS bit positions.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

  localparam int unsigned CFG_DW = 32;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_EDGE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int unsigned STAT_SERVICE_BIT = 31;
  localparam int unsigned STAT_INTR_BIT    = 30;

endpackage

// File: rtl/intr_prio_sel.sv
// Combinational winner selection over the eligible vector. Fixed lowest-index
// priority by default; rotating priority from start_i with INTC_ROUND_ROBIN_EN.
module intr_prio_sel
  import intr_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] elig_i,
`ifdef INTC_ROUND_ROBIN_EN
  input  logic [ID_W-1:0]    start_i,
`endif
  output logic [ID_W-1:0]    win_id_c,
  output logic               valid_c
);

`ifdef INTC_ROUND_ROBIN_EN
  logic [2*NUM_SRC-1:0] dbl_c;
  logic [NUM_SRC-1:0]   rot_c;
  int unsigned          idx_c;

  // Rotate so bit 0 is the start index; scanning downward leaves the lowest offset.
  always_comb begin
    dbl_c    = {elig_i, elig_i} >> start_i;
    rot_c    = dbl_c[NUM_SRC-1:0];
    win_id_c = '0;
    valid_c  = 1'b0;
    idx_c    = 0;
    for (int off = int'(NUM_SRC) - 1; off >= 0; off--) begin
      if (rot_c[off]) begin
        idx_c = 32'(start_i) + 32'(off);
        if (idx_c >= NUM_SRC) idx_c = idx_c - NUM_SRC;
        win_id_c = ID_W'(idx_c);
        valid_c  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_id_c = '0;
    valid_c  = |elig_i;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (elig_i[i]) win_id_c = ID_W'(i);
    end
  end
`endif

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller feeding the CPU control FSM.
// Optional rotating priority when INTC_ROUND_ROBIN_EN is defined.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic               INT_TAKEN,
  input  logic               MRET,
  input  logic               CFG_WE,
  input  logic [1:0]         CFG_ADDR,
  input  logic [CFG_DW-1:0]  CFG_WDATA,
  output logic [CFG_DW-1:0]  CFG_RDATA,
  output logic               INTR,
  output logic [ID_W-1:0]    INT_ID
);

  logic [NUM_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [NUM_SRC-1:0] enable_q, enable_d, edge_q, edge_d, pending_q, pending_d;
  logic [NUM_SRC-1:0] w1c_c, elig_now_c, elig_next_c;
  intr_state_t        state_q, state_d;
  logic [ID_W-1:0]    active_q, active_d, int_id_q, int_id_d, win_id_c;
  logic               intr_q, intr_d;
  logic               take_c, elig_any_c, win_valid_c;
  logic [CFG_DW-1:0]  status_c;
  logic               wdata_unused;

  assign wdata_unused = ^CFG_WDATA;

  assign take_c      = INT_TAKEN && (state_q == REQ);
  assign elig_now_c  = pending_q & enable_q;
  assign elig_any_c  = |elig_now_c;
  assign elig_next_c = pending_d & enable_d;

  // Synchronizer, config registers and pending capture.
  always_comb begin
    sync1_d   = IRQ_IN;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    enable_d  = enable_q;
    edge_d    = edge_q;
    pending_d = pending_q;
    w1c_c     = '0;
    if (CFG_WE) begin
      unique case (CFG_ADDR)
        ADDR_ENABLE:  enable_d = CFG_WDATA[NUM_SRC-1:0];
        ADDR_EDGE:    edge_d   = CFG_WDATA[NUM_SRC-1:0];
        ADDR_PENDING: w1c_c    = CFG_WDATA[NUM_SRC-1:0];
        default:      ;
      endcase
    end
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      // A new edge beats a simultaneous clear.
      if (edge_q[i]) begin
        pending_d[i] = (sync2_q[i] & ~prev_q[i]) |
                       (pending_q[i] & ~(w1c_c[i] | (take_c && (int_id_q == ID_W'(i)))));
      end else begin
        pending_d[i] = sync2_q[i];
      end
    end
  end

`ifdef INTC_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_q, last_d, rr_start_c;

  always_comb begin
    last_d     = take_c ? int_id_q : last_q;
    rr_start_c = ((32'(last_d) + 32'd1) >= NUM_SRC) ? '0 : ID_W'(32'(last_d) + 32'd1);
  end
`endif

  // Winner is evaluated on next-cycle eligibility so INT_ID can be registered.
  intr_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_sel (
    .elig_i   (elig_next_c),
`ifdef INTC_ROUND_ROBIN_EN
    .start_i  (rr_start_c),
`endif
    .win_id_c (win_id_c),
    .valid_c  (win_valid_c)
  );

  // Request/service FSM and registered outputs.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    int_id_d = '0;
    unique case (state_q)
      IDLE: if (elig_any_c) state_d = REQ;
      REQ: begin
        if (take_c) begin
          state_d  = SERVICE;
          active_d = int_id_q;
        end else if (!elig_any_c) begin
          state_d = IDLE;
        end
      end
      SERVICE: if (MRET) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    intr_d = (state_d == REQ);
    if (state_d == REQ && win_valid_c) begin
      int_id_d = win_id_c;
    end else if (state_d == SERVICE) begin
      int_id_d = active_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      state_q   <= IDLE;
      active_q  <= '0;
      int_id_q  <= '0;
      intr_q    <= 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
      last_q    <= '0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      active_q  <= active_d;
      int_id_q  <= int_id_d;
      intr_q    <= intr_d;
`ifdef INTC_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  always_comb begin
    status_c                   = '0;
    status_c[STAT_SERVICE_BIT] = (state_q == SERVICE);
    status_c[STAT_INTR_BIT]    = intr_q;
    status_c[ID_W-1:0]         = active_q;
  end

  always_comb begin
    unique case (CFG_ADDR)
      ADDR_ENABLE:  CFG_RDATA = CFG_DW'(enable_q);
      ADDR_EDGE:    CFG_RDATA = CFG_DW'(edge_q);
      ADDR_PENDING: CFG_RDATA = CFG_DW'(pending_q);
      default:      CFG_RDATA = status_c;
    endcase
  end

  assign INTR   = intr_q;
  assign INT_ID = int_id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: config vector table, directed corner
// sequences and a random run against a queue-based reference model.
module tb_intr_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  IRQ_IN;
  logic        INT_TAKEN, MRET, CFG_WE;
  logic [1:0]  CFG_ADDR;
  logic [31:0] CFG_WDATA, CFG_RDATA;
  logic        INTR;
  logic [2:0]  INT_ID;

  int n_checks = 0;
  int n_fail   = 0;

  intr_ctrl #(.NUM_SRC(8)) dut (
    .CLK(CLK), .RST(RST), .IRQ_IN(IRQ_IN), .INT_TAKEN(INT_TAKEN), .MRET(MRET),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_WDATA(CFG_WDATA),
    .CFG_RDATA(CFG_RDATA), .INTR(INTR), .INT_ID(INT_ID)
  );

  always #5 CLK = ~CLK;

  // Reference model: phase 0 idle, 1 requesting, 2 in service.
  bit [7:0] m_en, m_edge, m_pend;
  bit [7:0] m_iq[$];
  int       m_phase, m_active;
`ifdef INTC_ROUND_ROBIN_EN
  int       m_last;
`endif

  function automatic int pick(bit [7:0] e);
`ifdef INTC_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = (m_last + k) % 8;
      if (e[j]) return j;
    end
`else
    for (int j = 0; j < 8; j++) if (e[j]) return j;
`endif
    return 0;
  endfunction

  function automatic int exp_id();
    if (m_phase == 1) return pick(m_pend & m_en);
    if (m_phase == 2) return m_active;
    return 0;
  endfunction

  function automatic logic [31:0] exp_rdata(logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_en);
      2'd1:    return 32'(m_edge);
      2'd2:    return 32'(m_pend);
      default: return {(m_phase == 2), (m_phase == 1), 27'b0, 3'(m_active)};
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_edge = 0; m_pend = 0; m_phase = 0; m_active = 0;
`ifdef INTC_ROUND_ROBIN_EN
    m_last = 0;
`endif
    m_iq = '{8'h00, 8'h00, 8'h00};
  endtask

  // Advance the model across one rising edge using the inputs presently applied.
  task automatic model_update();
    bit [7:0] s2, pv, el, np;
    int w;
    bit take;
    s2 = m_iq[1];
    pv = m_iq[2];
    el = m_pend & m_en;
    w = pick(el);
    take = INT_TAKEN && (m_phase == 1);
    for (int i = 0; i < 8; i++) begin
      if (m_edge[i]) begin
        bit clr;
        clr = (CFG_WE && CFG_ADDR == 2'd2 && CFG_WDATA[i]) || (take && w == i);
        np[i] = (s2[i] && !pv[i]) || (m_pend[i] && !clr);
      end else begin
        np[i] = s2[i];
      end
    end
    case (m_phase)
      0: if (el != 0) m_phase = 1;
      1: begin
        if (take) begin
          m_active = w;
`ifdef INTC_ROUND_ROBIN_EN
          m_last = w;
`endif
          m_phase = 2;
        end else if (el == 0) begin
          m_phase = 0;
        end
      end
      2: if (MRET) m_phase = 0;
      default: m_phase = 0;
    endcase
    if (CFG_WE && CFG_ADDR == 2'd0) m_en = CFG_WDATA[7:0];
    if (CFG_WE && CFG_ADDR == 2'd1) m_edge = CFG_WDATA[7:0];
    m_pend = np;
    m_iq.push_front(IRQ_IN);
    void'(m_iq.pop_back());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    check("model_intr", 32'(INTR), 32'(m_phase == 1));
    check("model_int_id", 32'(INT_ID), 32'(exp_id()));
    check("model_rdata", CFG_RDATA, exp_rdata(CFG_ADDR));
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_WDATA = d;
    step();
    CFG_WE = 1'b0;
  endtask

  task automatic pulse_taken();
    INT_TAKEN = 1'b1; step(); INT_TAKEN = 1'b0;
  endtask

  task automatic pulse_mret();
    MRET = 1'b1; step(); MRET = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    CFG_ADDR = a;
    #1;
    check(name, CFG_RDATA, exp);
  endtask

  task automatic wait_intr(input int max_cycles);
    int k;
    k = 0;
    while (!INTR && k < max_cycles) begin
      step();
      k++;
    end
    check("wait_intr", 32'(INTR), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } cfg_vec_t;

  cfg_vec_t vecs[8];
  int       exp_ids[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 32'hFFFF_FFA5, 2'd0, 32'h0000_00A5};
    vecs[1] = '{2'd1, 32'hDEAD_BE3C, 2'd1, 32'h0000_003C};
    vecs[2] = '{2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    vecs[3] = '{2'd2, 32'h0000_00FF, 2'd2, 32'h0000_0000};
    vecs[4] = '{2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
    vecs[5] = '{2'd1, 32'hFFFF_FF00, 2'd1, 32'h0000_0000};
    vecs[6] = '{2'd0, 32'h0000_0100, 2'd0, 32'h0000_0000};
    vecs[7] = '{2'd1, 32'h0000_0081, 2'd1, 32'h0000_0081};
`ifdef INTC_ROUND_ROBIN_EN
    exp_ids = '{1, 4, 1, 4};
`else
    exp_ids = '{1, 1, 1, 1};
`endif

    // Reset with all lines high and nothing enabled.
    RST = 1'b0; IRQ_IN = 8'hFF; INT_TAKEN = 1'b0; MRET = 1'b0;
    CFG_WE = 1'b0; CFG_ADDR = 2'd3; CFG_WDATA = '0;
    model_reset();
    #12;
    check("rst_intr", 32'(INTR), 32'd0);
    check("rst_int_id", 32'(INT_ID), 32'd0);
    read_check("rst_status", 2'd3, 32'd0);
    read_check("rst_pending", 2'd2, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) step();
    read_check("level_pending_ff", 2'd2, 32'h0000_00FF);
    check("level_no_intr", 32'(INTR), 32'd0);
    read_check("level_status", 2'd3, 32'd0);
    IRQ_IN = 8'h00;
    repeat (3) step();

    // Register write/read table.
    for (int i = 0; i < 8; i++) begin
      cfg_write(vecs[i].waddr, vecs[i].wdata);
      read_check($sformatf("cfg_vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Single edge on source 3: request appears three edges after capture.
    cfg_write(2'd0, 32'h0C);
    cfg_write(2'd1, 32'h0C);
    IRQ_IN = 8'h08;
    step();
    IRQ_IN = 8'h00;
    step();
    step();
    check("edge3_k2_intr", 32'(INTR), 32'd0);
    step();
    check("edge3_k3_intr", 32'(INTR), 32'd1);
    check("edge3_k3_id", 32'(INT_ID), 32'd3);
    pulse_taken();
    read_check("edge3_pend_clr", 2'd2, 32'd0);
    read_check("edge3_status", 2'd3, 32'h8000_0003);
    repeat (3) step();
    check("edge3_svc_intr", 32'(INTR), 32'd0);
    pulse_mret();
    check("edge3_mret_intr", 32'(INTR), 32'd0);

    // Simultaneous edges on 2 and 3: 2 first, 3 right after MRET.
    IRQ_IN = 8'h0C;
    step();
    IRQ_IN = 8'h00;
    repeat (3) step();
    check("dual_intr", 32'(INTR), 32'd1);
    check("dual_first_id", 32'(INT_ID), 32'd2);
    pulse_taken();
    read_check("dual_status", 2'd3, 32'h8000_0002);
    read_check("dual_pend3", 2'd2, 32'h0000_0008);
    pulse_mret();
    check("dual_mret_idle", 32'(INTR), 32'd0);
    step();
    check("dual_reassert", 32'(INTR), 32'd1);
    check("dual_second_id", 32'(INT_ID), 32'd3);
    pulse_taken();
    pulse_mret();

    // Level source 5 withdrawn before it is taken.
    cfg_write(2'd0, 32'h20);
    IRQ_IN = 8'h20;
    wait_intr(8);
    check("lvl5_id", 32'(INT_ID), 32'd5);
    IRQ_IN = 8'h00;
    repeat (3) step();
    check("lvl5_drop_k2", 32'(INTR), 32'd1);
    step();
    check("lvl5_drop_k3", 32'(INTR), 32'd0);

    // W1C racing a newly detected edge on source 2.
    cfg_write(2'd0, 32'h00);
    cfg_write(2'd1, 32'h04);
    IRQ_IN = 8'h04;
    step();
    IRQ_IN = 8'h00;
    step();
    cfg_write(2'd2, 32'h04);
    read_check("w1c_race_pend", 2'd2, 32'h0000_0004);
    cfg_write(2'd2, 32'h04);
    read_check("w1c_alone_pend", 2'd2, 32'h0000_0000);

    // Sources 1 and 4 held at level: service order depends on priority mode.
    cfg_write(2'd1, 32'h00);
    cfg_write(2'd0, 32'h12);
    IRQ_IN = 8'h12;
    for (int r = 0; r < 4; r++) begin
      wait_intr(8);
      check($sformatf("order%0d_id", r), 32'(INT_ID), 32'(exp_ids[r]));
      pulse_taken();
      read_check($sformatf("order%0d_status", r), 2'd3, 32'h8000_0000 | 32'(exp_ids[r]));
      pulse_mret();
    end

    // Asynchronous reset while in service.
    wait_intr(8);
    pulse_taken();
    CFG_ADDR = 2'd3;
    #2;
    RST = 1'b0;
    #1;
    check("midrst_intr", 32'(INTR), 32'd0);
    check("midrst_int_id", 32'(INT_ID), 32'd0);
    check("midrst_status", CFG_RDATA, 32'd0);
    model_reset();
    IRQ_IN = 8'h00;
    @(negedge CLK);
    read_check("midrst_pending", 2'd2, 32'd0);
    RST = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) IRQ_IN = 8'($urandom);
      CFG_WE    = ($urandom_range(0, 7) == 0);
      CFG_ADDR  = 2'($urandom);
      CFG_WDATA = $urandom;
      INT_TAKEN = ($urandom_range(0, 2) == 0);
      MRET      = ($urandom_range(0, 4) == 0);
      step();
    end
    CFG_WE = 1'b0; INT_TAKEN = 1'b0; MRET = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
